// File: rtl/alu_exmem_stage.sv
// EX/MEM pipeline register built as a 2-entry skid buffer with ALU exception
// screening: excepted beats are forwarded with writeback suppressed and logged.
module alu_exmem_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_v,
    input  logic [2:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic              in_regwrite,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    output logic [4:0]        out_rd,
    output logic              out_regwrite,
    output logic              exc_ovf,
    output logic              exc_ill,
    output logic [7:0]        exc_cnt,
    input  logic              exc_clear,
    output logic [1:0]        dbg_state
);

    // Handshake: a beat moves on a rising edge only when valid and ready are
    // both high at that edge; valid never waits on ready, and a presented
    // beat holds its payload until it is taken.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] head_result, tail_result;
    logic [4:0]        head_rd, tail_rd;
    logic              head_rw, tail_rw;

    logic accept, drain, take;
    logic head_ld_in, head_ld_tail, tail_ld;
    logic op_arith, ovf_hit, ill_hit, exc_hit, exc_take, gated_rw;

    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;
    assign take      = accept & ~flush;
    assign out_valid = (state_q != EMPTY);
    assign dbg_state = state_q;

    assign op_arith = (in_op == 3'b010) || (in_op == 3'b110);
    assign ovf_hit  = in_v & op_arith;
    assign ill_hit  = (in_op == 3'b011) || (in_op == 3'b100) || (in_op == 3'b101);
    assign exc_hit  = ovf_hit | ill_hit;
    assign exc_take = take & exc_hit;
    assign gated_rw = in_regwrite & ~exc_hit;

    always_comb begin
        state_d      = state_q;
        head_ld_in   = 1'b0;
        head_ld_tail = 1'b0;
        tail_ld      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d    = ONE;
                    head_ld_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    head_ld_in = 1'b1;
                end else if (accept) begin
                    state_d = TWO;
                    tail_ld = 1'b1;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (drain) begin
                    state_d      = ONE;
                    head_ld_tail = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        // A flush drops everything, including a beat arriving this cycle.
        if (flush) begin
            state_d      = EMPTY;
            head_ld_in   = 1'b0;
            head_ld_tail = 1'b0;
            tail_ld      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state_q  <= state_d;
            in_ready <= (state_d != TWO);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_result <= '0;
            head_rd     <= '0;
            head_rw     <= 1'b0;
            tail_result <= '0;
            tail_rd     <= '0;
            tail_rw     <= 1'b0;
        end else begin
            if (head_ld_in) begin
                head_result <= in_result;
                head_rd     <= in_rd;
                head_rw     <= gated_rw;
            end else if (head_ld_tail) begin
                head_result <= tail_result;
                head_rd     <= tail_rd;
                head_rw     <= tail_rw;
            end
            if (tail_ld) begin
                tail_result <= in_result;
                tail_rd     <= in_rd;
                tail_rw     <= gated_rw;
            end
        end
    end

    assign out_result   = head_result;
    assign out_zero     = (head_result == '0);
    assign out_rd       = head_rd;
    assign out_regwrite = head_rw;

    // A clear coinciding with an excepted accept leaves exactly that one logged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exc_ovf <= 1'b0;
            exc_ill <= 1'b0;
            exc_cnt <= 8'd0;
        end else if (exc_clear) begin
            exc_ovf <= exc_take & ovf_hit;
            exc_ill <= exc_take & ill_hit;
            exc_cnt <= exc_take ? 8'd1 : 8'd0;
        end else if (exc_take) begin
            if (ovf_hit) exc_ovf <= 1'b1;
            if (ill_hit) exc_ill <= 1'b1;
            if (exc_cnt != 8'hFF) exc_cnt <= exc_cnt + 8'd1;
        end
    end

endmodule
